mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported, variable-latency backing memory between the pipeline's instruction-fetch port and its data-memory (MEM-stage) port. It sits between the fetch/MEM stages of the pipelined processor and the memory model. It sequences one transaction at a time and gives data accesses priority over fetches. Requesters see `*_stall` while they wait. A watchdog recovers from a memory that never answers.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// data access. Data wins; one transaction in flight; a watchdog recovers from a silent memory.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          dm_rd,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          dm_stall,
    input  logic          halt,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DM_WAIT,
        IF_WAIT
    } state_t;

    state_t          state_reg, state_next;
    logic            mem_en_reg, mem_en_next;
    logic            mem_wr_reg, mem_wr_next;
    logic [AW-1:0]   mem_addr_reg, mem_addr_next;
    logic [DW-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [DW-1:0]   if_rdata_reg, if_rdata_next;
    logic [DW-1:0]   dm_rdata_reg, dm_rdata_next;
    logic            if_done_reg, if_done_next;
    logic            dm_done_reg, dm_done_next;
    logic            err_reg, err_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic            dm_req;
    logic            dm_eligible;
    logic            if_eligible;
    logic [DW-1:0]   load_data;

    // A write returns zero as its completion data.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_load
            assign load_data[gi] = mem_rdata[gi] & ~mem_wr_reg;
        end
    endgenerate

    // A requester whose done pulse is high right now still shows its old request.
    assign dm_req      = dm_rd | dm_wr;
    assign dm_eligible = dm_req & ~dm_done_reg;
    assign if_eligible = if_req & ~if_done_reg & ~halt;

    always_comb begin
        state_next     = state_reg;
        mem_en_next    = 1'b0;
        mem_wr_next    = mem_wr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        if_done_next   = 1'b0;
        dm_done_next   = 1'b0;
        err_next       = err_reg;
        cnt_next       = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (dm_eligible) begin
                    mem_addr_next  = dm_addr;
                    mem_wdata_next = dm_wdata;
                    mem_wr_next    = dm_wr;
                    mem_en_next    = 1'b1;
                    cnt_next       = CW'(1);
                    state_next     = DM_WAIT;
                    if (dm_rd && dm_wr) begin
                        err_next = 1'b1;
                    end
                end else if (if_eligible) begin
                    mem_addr_next = if_addr;
                    mem_wr_next   = 1'b0;
                    mem_en_next   = 1'b1;
                    cnt_next      = CW'(1);
                    state_next    = IF_WAIT;
                end
            end
            DM_WAIT, IF_WAIT: begin
                if (mem_done) begin
                    if (state_reg == DM_WAIT) begin
                        dm_rdata_next = load_data;
                        dm_done_next  = 1'b1;
                    end else begin
                        if_rdata_next = load_data;
                        if_done_next  = 1'b1;
                    end
                    state_next = IDLE;
                end else if (cnt_reg == CW'(TIMEOUT)) begin
                    err_next = 1'b1;
                    if (state_reg == DM_WAIT) begin
                        dm_rdata_next = '0;
                        dm_done_next  = 1'b1;
                    end else begin
                        if_rdata_next = '0;
                        if_done_next  = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            mem_en_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            dm_rdata_reg  <= '0;
            if_done_reg   <= 1'b0;
            dm_done_reg   <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            mem_en_reg    <= mem_en_next;
            mem_wr_reg    <= mem_wr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
            if_done_reg   <= if_done_next;
            dm_done_reg   <= dm_done_next;
            err_reg       <= err_next;
            cnt_reg       <= cnt_next;
        end
    end

    assign mem_en    = mem_en_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign if_done   = if_done_reg;
    assign dm_done   = dm_done_reg;
    assign err       = err_reg;
    assign if_stall  = if_req & ~if_done_reg;
    assign dm_stall  = dm_req & ~dm_done_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_stall;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          dm_stall;
    logic          halt;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          err;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .halt(halt),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        dm_rd;
        logic        dm_wr;
        logic [15:0] dm_addr;
        logic [15:0] dm_wdata;
        logic        mem_done;
        logic [15:0] mem_rdata;
        logic        e_en;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_ifd;
        logic        e_dmd;
        logic [15:0] e_ifr;
        logic [15:0] e_dmr;
    } vec_t;

    vec_t tbl[15];

    // reference model state for the random phase
    bit          m_busy, m_is_dm, m_wr, m_err;
    int          m_age;
    logic [15:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
    bit          e_en, e_ifd, e_dmd;
    bit          n_en, n_ifd, n_dmd;
    bit          mem_act;
    int          mem_lat;
    bit          dm_live, if_live;

    task automatic model_finish(input logic [15:0] val);
        if (m_is_dm) begin
            m_dm_rd = val;
            n_dmd   = 1'b1;
        end else begin
            m_if_rd = val;
            n_ifd   = 1'b1;
        end
        m_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b0; if_req = 0; if_addr = 0; dm_rd = 0; dm_wr = 0;
        dm_addr = 0; dm_wdata = 0; halt = 0; mem_rdata = 0; mem_done = 0;

        //             if  ifaddr   rd wr dmaddr   wdata    md memrd    en wr addr     wdata    ifd dmd ifr      dmr
        tbl[0]  = '{1'b1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'hC0DE, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 1, 0, 16'hC0DE, 16'h0000};
        tbl[6]  = '{1'b1, 16'h0020, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'hC0DE, 16'h0000};
        tbl[7]  = '{1'b1, 16'h0020, 1, 0, 16'h0200, 16'h0000, 1, 16'hBEEF, 1, 0, 16'h0200, 16'h0000, 0, 0, 16'hC0DE, 16'h0000};
        tbl[8]  = '{1'b1, 16'h0020, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 0, 16'h0200, 16'h0000, 0, 1, 16'hC0DE, 16'hBEEF};
        tbl[9]  = '{1'b1, 16'h0020, 0, 0, 16'h0200, 16'h0000, 1, 16'h1111, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'hC0DE, 16'hBEEF};
        tbl[10] = '{1'b0, 16'h0020, 0, 1, 16'h0040, 16'h1234, 0, 16'h0000, 0, 0, 16'h0020, 16'h0000, 1, 0, 16'h1111, 16'hBEEF};
        tbl[11] = '{1'b0, 16'h0020, 0, 1, 16'h0040, 16'h1234, 0, 16'h0000, 1, 1, 16'h0040, 16'h1234, 0, 0, 16'h1111, 16'hBEEF};
        tbl[12] = '{1'b0, 16'h0020, 0, 1, 16'h0040, 16'h1234, 1, 16'hFFFF, 0, 1, 16'h0040, 16'h1234, 0, 0, 16'h1111, 16'hBEEF};
        tbl[13] = '{1'b0, 16'h0020, 0, 1, 16'h0040, 16'h1234, 0, 16'h0000, 0, 1, 16'h0040, 16'h1234, 0, 1, 16'h1111, 16'h0000};
        tbl[14] = '{1'b0, 16'h0020, 0, 0, 16'h0040, 16'h1234, 0, 16'h0000, 0, 1, 16'h0040, 16'h1234, 0, 0, 16'h1111, 16'h0000};

        step(); step();
        chk("reset_mem_en", mem_en, 0);
        chk("reset_err", err, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_if_done", if_done, 0);
        rst = 1'b1;

        // directed vectors: fetch alone, simultaneous requests, store
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("row%0d_mem_en", k), mem_en, tbl[k].e_en);
            chk($sformatf("row%0d_mem_wr", k), mem_wr, tbl[k].e_wr);
            chk($sformatf("row%0d_mem_addr", k), mem_addr, tbl[k].e_addr);
            chk($sformatf("row%0d_mem_wdata", k), mem_wdata, tbl[k].e_wdata);
            chk($sformatf("row%0d_if_done", k), if_done, tbl[k].e_ifd);
            chk($sformatf("row%0d_dm_done", k), dm_done, tbl[k].e_dmd);
            chk($sformatf("row%0d_if_rdata", k), if_rdata, tbl[k].e_ifr);
            chk($sformatf("row%0d_dm_rdata", k), dm_rdata, tbl[k].e_dmr);
            chk($sformatf("row%0d_err", k), err, 0);
            if_req = tbl[k].if_req; if_addr = tbl[k].if_addr;
            dm_rd = tbl[k].dm_rd; dm_wr = tbl[k].dm_wr;
            dm_addr = tbl[k].dm_addr; dm_wdata = tbl[k].dm_wdata;
            mem_done = tbl[k].mem_done; mem_rdata = tbl[k].mem_rdata;
            #1;
            chk($sformatf("row%0d_if_stall", k), if_stall, tbl[k].if_req & ~tbl[k].e_ifd);
            chk($sformatf("row%0d_dm_stall", k), dm_stall,
                (tbl[k].dm_rd | tbl[k].dm_wr) & ~tbl[k].e_dmd);
            $display("row %0d applied", k);
            step();
        end

        // halt: in-flight fetch completes, no new fetch grant, data still served
        if_req = 1; if_addr = 16'h0030; step();
        chk("halt_fetch_en", mem_en, 1);
        chk("halt_fetch_addr", mem_addr, 16'h0030);
        halt = 1; step();
        mem_done = 1; mem_rdata = 16'hAAAA; step();
        chk("halt_fetch_done", if_done, 1);
        chk("halt_fetch_rdata", if_rdata, 16'hAAAA);
        mem_done = 0; step();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("halt_no_en%0d", i), mem_en, 0);
            chk($sformatf("halt_stall%0d", i), if_stall, 1);
            step();
        end
        dm_rd = 1; dm_addr = 16'h0300; step();
        chk("halt_dm_en", mem_en, 1);
        chk("halt_dm_addr", mem_addr, 16'h0300);
        mem_done = 1; mem_rdata = 16'h5555; step();
        chk("halt_dm_done", dm_done, 1);
        chk("halt_dm_rdata", dm_rdata, 16'h5555);
        mem_done = 0; dm_rd = 0; step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("halt_after_dm_no_en%0d", i), mem_en, 0);
            step();
        end
        if_req = 0; halt = 0; step();
        $display("halt sequence done");

        // watchdog: memory never answers
        dm_rd = 1; dm_addr = 16'h0400; step();
        chk("to_en", mem_en, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("to_wait_done%0d", i), dm_done, 0);
            chk($sformatf("to_wait_err%0d", i), err, 0);
            chk($sformatf("to_wait_addr%0d", i), mem_addr, 16'h0400);
        end
        step();
        chk("to_done", dm_done, 1);
        chk("to_rdata", dm_rdata, 0);
        chk("to_err", err, 1);
        dm_rd = 0; step();
        chk("to_err_sticky", err, 1);
        chk("to_done_pulse", dm_done, 0);
        $display("timeout sequence done");

        // reset mid-transaction, late mem_done after release
        dm_wr = 1; dm_addr = 16'h0500; dm_wdata = 16'h7777; step();
        chk("rst_pre_en", mem_en, 1);
        chk("rst_pre_wdata", mem_wdata, 16'h7777);
        step();
        #1 rst = 0;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_err", err, 0);
        dm_wr = 0;
        step();
        rst = 1; mem_done = 1; mem_rdata = 16'h9999; step();
        mem_done = 0;
        chk("rst_late_dm_done", dm_done, 0);
        chk("rst_late_if_done", if_done, 0);
        chk("rst_late_en", mem_en, 0);
        step();
        chk("rst_late_dm_done2", dm_done, 0);
        chk("rst_late_dm_rdata", dm_rdata, 0);
        $display("reset sequence done");

        // random traffic against the reference model
        rst = 0; step(); rst = 1;
        m_busy = 0; m_is_dm = 0; m_wr = 0; m_err = 0; m_age = 0;
        m_addr = 0; m_wdata = 0; m_if_rd = 0; m_dm_rd = 0;
        e_en = 0; e_ifd = 0; e_dmd = 0; mem_act = 0; mem_lat = 0;
        dm_live = 0; if_live = 0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            int bad_before;
            bad_before = bad;
            chk("rnd_mem_en", mem_en, e_en);
            chk("rnd_mem_wr", mem_wr, m_wr);
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_wdata", mem_wdata, m_wdata);
            chk("rnd_if_done", if_done, e_ifd);
            chk("rnd_dm_done", dm_done, e_dmd);
            chk("rnd_if_rdata", if_rdata, m_if_rd);
            chk("rnd_dm_rdata", dm_rdata, m_dm_rd);
            chk("rnd_err", err, m_err);

            // requesters hold until done, sometimes leave a stale request up
            if (e_dmd && ($urandom % 2 == 0)) begin
                dm_rd = 0; dm_wr = 0; dm_live = 0;
            end else if (!dm_live && ($urandom % 4 == 0)) begin
                r = int'($urandom % 32);
                dm_rd = (r == 0) || (r >= 16);
                dm_wr = (r < 16);
                dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
                dm_live = 1;
            end
            if (e_ifd && ($urandom % 2 == 0)) begin
                if_req = 0; if_live = 0;
            end else if (!if_live && ($urandom % 3 == 0)) begin
                if_req = 1; if_addr = 16'($urandom); if_live = 1;
            end
            if ($urandom % 12 == 0) halt = ~halt;

            // memory: latency 0..3 after mem_en, occasionally never, stray pulses while idle
            mem_done = 0; mem_rdata = 16'($urandom);
            if (e_en) begin
                r = int'($urandom % 16);
                mem_act = 1;
                mem_lat = (r == 15) ? 1000 : (r % 4);
            end
            if (mem_act) begin
                if (mem_lat == 0) begin
                    mem_done = 1; mem_act = 0;
                end else begin
                    mem_lat--;
                end
            end else if ($urandom % 8 == 0) begin
                mem_done = 1;
            end

            #1;
            chk("rnd_if_stall", if_stall, if_req & ~e_ifd);
            chk("rnd_dm_stall", dm_stall, (dm_rd | dm_wr) & ~e_dmd);

            n_en = 0; n_ifd = 0; n_dmd = 0;
            if (m_busy) begin
                if (mem_done) begin
                    model_finish(m_wr ? 16'h0000 : mem_rdata);
                end else if (m_age == TO) begin
                    model_finish(16'h0000);
                    m_err = 1; mem_act = 0;
                end else begin
                    m_age++;
                end
            end else if ((dm_rd | dm_wr) && !e_dmd) begin
                m_busy = 1; m_is_dm = 1; m_age = 1; n_en = 1;
                m_addr = dm_addr; m_wdata = dm_wdata; m_wr = dm_wr;
                if (dm_rd && dm_wr) m_err = 1;
            end else if (if_req && !e_ifd && !halt) begin
                m_busy = 1; m_is_dm = 0; m_age = 1; n_en = 1;
                m_addr = if_addr; m_wr = 0;
            end
            e_en = n_en; e_ifd = n_ifd; e_dmd = n_dmd;
            if (n % 250 == 0 || bad != bad_before)
                $display("rnd cycle %0d busy=%0d dm=%0d err=%0d", n, m_busy, m_is_dm, m_err);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
